// File: rtl/pke_pkg.sv
// Shared PKE definitions: datapath widths, error bit positions, legacy RAM bases
// and the arbiter state encoding.
package pke_pkg;

  localparam int PKE_DW = 64;
  localparam int PKE_AW = 9;

  localparam int ERR_NONOWN  = 0;
  localparam int ERR_RESTART = 1;
  localparam int ERR_MIRROR  = 2;

  // Fixed offsets used by the old port mux, kept for firmware that still programs them as bases
  localparam logic [PKE_AW-1:0] N_BASE_ECC = 9'h024;
  localparam logic [PKE_AW-1:0] M_BASE_ECC = 9'h02D;
  localparam logic [PKE_AW-1:0] N_BASE_RSA = 9'h100;
  localparam logic [PKE_AW-1:0] M_BASE_RSA = 9'h180;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arbState_t;

endpackage

// File: rtl/pke_ram_arbiter_if.sv
// Engine-side and RAM-side bus of the PKE RAM arbiter; slave is the arbiter view,
// master is the view of whoever drives the engines and models the RAM.
interface pke_ram_arbiter_if import pke_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DW     = PKE_DW,
  parameter int AW     = PKE_AW
);
  logic [NUM_CH-1:0]    ChStart, ChDone, ChMirror;
  logic [NUM_CH-1:0]    ChRd0, ChWr0, ChRd1, ChWr1;
  logic [NUM_CH*AW-1:0] ChAddr0, ChAddr1, ChBase0, ChBase1;
  logic [NUM_CH*DW-1:0] ChDat0, ChDat1;
  logic [DW-1:0]        ChQ0, ChQ1;
  logic [NUM_CH-1:0]    ChQValid0, ChQValid1;
  logic                 RamRd0, RamWr0, RamRd1, RamWr1;
  logic [AW-1:0]        RamAddr0, RamAddr1;
  logic [DW-1:0]        RamDat0, RamDat1, RamQ0, RamQ1;

  modport slave (
    input  ChStart, ChDone, ChMirror, ChRd0, ChWr0, ChRd1, ChWr1,
    input  ChAddr0, ChAddr1, ChBase0, ChBase1, ChDat0, ChDat1,
    input  RamQ0, RamQ1,
    output ChQ0, ChQ1, ChQValid0, ChQValid1,
    output RamRd0, RamWr0, RamRd1, RamWr1, RamAddr0, RamAddr1, RamDat0, RamDat1
  );

  modport master (
    output ChStart, ChDone, ChMirror, ChRd0, ChWr0, ChRd1, ChWr1,
    output ChAddr0, ChAddr1, ChBase0, ChBase1, ChDat0, ChDat1,
    output RamQ0, RamQ1,
    input  ChQ0, ChQ1, ChQValid0, ChQValid1,
    input  RamRd0, RamWr0, RamRd1, RamWr1, RamAddr0, RamAddr1, RamDat0, RamDat1
  );

endinterface

// File: rtl/pke_rr_pick.sv
// Round-robin one-hot picker: grants the first requester strictly after lastPtr,
// wrapping around, so the previous owner has the lowest priority.
module pke_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     lastPtr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grantIdx,
  output logic              anyReq
);

  logic [CW-1:0] idx;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CW'((int'(lastPtr) + i) % NUM_CH);
      if (!anyReq && req[idx]) begin
        anyReq      = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end

endmodule

// File: rtl/pke_ram_arbiter.sv
// Start/done ownership arbiter putting NUM_CH PKE engines onto the dual-port PKE RAM,
// with per-channel base relocation, port-0 to port-1 write mirroring and read-return routing.
module pke_ram_arbiter import pke_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DW     = PKE_DW,
  parameter int AW     = PKE_AW,
  parameter int RD_LAT = 1
)(
  input  logic               Clk,
  input  logic               Resetn,
  pke_ram_arbiter_if.slave   bus,
  input  logic               ErrClr,
  output logic [NUM_CH-1:0]  Grant,
  output logic               Busy,
  output logic [2:0]         Err
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

  arbState_t         state;
  logic [CW-1:0]     ownerIdx, lastPtr, pickIdx;
  logic [NUM_CH-1:0] pending, reqVec, pickGrant, chStrobe;
  logic              pickAny, ownActive, hasOwner, mirrorHit;
  logic [1:0]        drainCnt;
  logic [2:0]        errSet;

  logic              ownRd0, ownWr0, ownRd1, ownWr1, ownMirror, ownStart, ownDone;
  logic [AW-1:0]     ownAddr0, ownAddr1, ownBase0, ownBase1;
  logic [DW-1:0]     ownDat0, ownDat1;

  logic              ramRd0, ramWr0, ramRd1, ramWr1;
  logic [AW-1:0]     ramAddr0, ramAddr1;
  logic [DW-1:0]     ramDat0, ramDat1;
  logic [NUM_CH-1:0] qValid0, qValid1;

  logic [RD_LAT-1:0] vld0Pipe, vld1Pipe;
  logic [CW-1:0]     idx0Pipe [RD_LAT];
  logic [CW-1:0]     idx1Pipe [RD_LAT];

  assign ownActive = (state == ST_OWN);
  assign hasOwner  = (state != ST_IDLE);
  assign reqVec    = pending | bus.ChStart;
  assign Busy      = hasOwner;

  pke_rr_pick #(.NUM_CH(NUM_CH), .CW(CW)) uPick (
    .req      (reqVec),
    .lastPtr  (lastPtr),
    .grant    (pickGrant),
    .grantIdx (pickIdx),
    .anyReq   (pickAny)
  );

  always_comb begin
    ownRd0    = bus.ChRd0[ownerIdx];
    ownWr0    = bus.ChWr0[ownerIdx];
    ownRd1    = bus.ChRd1[ownerIdx];
    ownWr1    = bus.ChWr1[ownerIdx];
    ownMirror = bus.ChMirror[ownerIdx];
    ownStart  = bus.ChStart[ownerIdx];
    ownDone   = bus.ChDone[ownerIdx];
    ownAddr0  = bus.ChAddr0[ownerIdx*AW +: AW];
    ownAddr1  = bus.ChAddr1[ownerIdx*AW +: AW];
    ownBase0  = bus.ChBase0[ownerIdx*AW +: AW];
    ownBase1  = bus.ChBase1[ownerIdx*AW +: AW];
    ownDat0   = bus.ChDat0[ownerIdx*DW +: DW];
    ownDat1   = bus.ChDat1[ownerIdx*DW +: DW];
  end

  // Strobes only pass while owning; addresses and data follow the owner through DRAIN too.
  always_comb begin
    mirrorHit = ownActive & ownMirror & ownWr0;
    ramRd0    = ownActive & ownRd0;
    ramWr0    = ownActive & ownWr0;
    ramAddr0  = hasOwner ? AW'(ownBase0 + ownAddr0) : '0;
    ramDat0   = hasOwner ? ownDat0 : '0;
    ramRd1    = ownActive & ownRd1;
    ramWr1    = ownActive & ownWr1;
    ramAddr1  = hasOwner ? AW'(ownBase1 + ownAddr1) : '0;
    ramDat1   = hasOwner ? ownDat1 : '0;
    if (mirrorHit) begin
      ramRd1   = 1'b0;
      ramWr1   = 1'b1;
      ramAddr1 = ramAddr0;
      ramDat1  = ramDat0;
    end
  end

  always_comb begin
    chStrobe              = bus.ChRd0 | bus.ChWr0 | bus.ChRd1 | bus.ChWr1;
    errSet                = '0;
    errSet[ERR_NONOWN]    = |(chStrobe & ~Grant);
    errSet[ERR_RESTART]   = ownActive & ownStart;
    errSet[ERR_MIRROR]    = mirrorHit & (ownWr1 | ownRd1);
  end

  // Ownership FSM; Grant and the owner index are registered so access starts one cycle after Start.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_IDLE;
      Grant    <= '0;
      ownerIdx <= '0;
      lastPtr  <= CW'(NUM_CH - 1);
      pending  <= '0;
      drainCnt <= '0;
      Err      <= '0;
    end else begin
      Err <= ErrClr ? 3'b000 : (Err | errSet);
      case (state)
        ST_IDLE: begin
          if (pickAny) begin
            state    <= ST_OWN;
            Grant    <= pickGrant;
            ownerIdx <= pickIdx;
            lastPtr  <= pickIdx;
            pending  <= reqVec & ~pickGrant;
          end
        end
        ST_OWN: begin
          pending <= pending | (bus.ChStart & ~Grant);
          if (ownDone) begin
            state    <= ST_DRAIN;
            drainCnt <= DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          if (drainCnt != 2'd0) begin
            drainCnt <= drainCnt - 2'd1;
            pending  <= reqVec;
          end else if (pickAny) begin
            state    <= ST_OWN;
            Grant    <= pickGrant;
            ownerIdx <= pickIdx;
            lastPtr  <= pickIdx;
            pending  <= reqVec & ~pickGrant;
          end else begin
            state    <= ST_IDLE;
            Grant    <= '0;
            pending  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          Grant <= '0;
        end
      endcase
    end
  end

  // Each read strobe carries the issuing owner's index so late returns reach the old owner during DRAIN.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      vld0Pipe <= '0;
      vld1Pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        idx0Pipe[i] <= '0;
        idx1Pipe[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld0Pipe[i] <= vld0Pipe[i-1];
        vld1Pipe[i] <= vld1Pipe[i-1];
        idx0Pipe[i] <= idx0Pipe[i-1];
        idx1Pipe[i] <= idx1Pipe[i-1];
      end
      vld0Pipe[0] <= ramRd0;
      vld1Pipe[0] <= ramRd1;
      idx0Pipe[0] <= ownerIdx;
      idx1Pipe[0] <= ownerIdx;
    end
  end

  always_comb begin
    qValid0 = '0;
    qValid1 = '0;
    if (vld0Pipe[RD_LAT-1]) qValid0[idx0Pipe[RD_LAT-1]] = 1'b1;
    if (vld1Pipe[RD_LAT-1]) qValid1[idx1Pipe[RD_LAT-1]] = 1'b1;
  end

  assign bus.RamRd0    = ramRd0;
  assign bus.RamWr0    = ramWr0;
  assign bus.RamRd1    = ramRd1;
  assign bus.RamWr1    = ramWr1;
  assign bus.RamAddr0  = ramAddr0;
  assign bus.RamAddr1  = ramAddr1;
  assign bus.RamDat0   = ramDat0;
  assign bus.RamDat1   = ramDat1;
  assign bus.ChQ0      = bus.RamQ0;
  assign bus.ChQ1      = bus.RamQ1;
  assign bus.ChQValid0 = qValid0;
  assign bus.ChQValid1 = qValid1;

endmodule

// File: tb/tb_pke_ram_arbiter.sv
// Directed bench for pke_ram_arbiter: instance A uses RD_LAT=1, instance B uses RD_LAT=3;
// read returns are checked by a queue-based monitor, everything else inline.
module tb_pke_ram_arbiter;
  import pke_pkg::*;

  localparam logic [63:0] Q0A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] Q1A = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] Q0B = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] Q1B = 64'h0F0F_F0F0_1E1E_E1E1;

  typedef struct {
    int          port;
    logic [3:0]  vld;
    logic [63:0] dat;
    int          due;
  } ret_t;

  logic       Clk = 1'b0;
  logic       resetA, resetB, errClrA, errClrB, busyA, busyB;
  logic [3:0] grantA, grantB;
  logic [2:0] errA, errB;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         k;
  ret_t       expA[$];
  ret_t       expB[$];

  pke_ram_arbiter_if #(.NUM_CH(4), .DW(64), .AW(9)) ifA ();
  pke_ram_arbiter_if #(.NUM_CH(4), .DW(64), .AW(9)) ifB ();

  pke_ram_arbiter #(.NUM_CH(4), .DW(64), .AW(9), .RD_LAT(1)) dutA (
    .Clk(Clk), .Resetn(resetA), .bus(ifA), .ErrClr(errClrA),
    .Grant(grantA), .Busy(busyA), .Err(errA)
  );

  pke_ram_arbiter #(.NUM_CH(4), .DW(64), .AW(9), .RD_LAT(3)) dutB (
    .Clk(Clk), .Resetn(resetB), .bus(ifB), .ErrClr(errClrB),
    .Grant(grantB), .Busy(busyB), .Err(errB)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic ret_t mkRet(input int port, input logic [3:0] vld, input logic [63:0] dat, input int due);
    ret_t r;
    r.port = port;
    r.vld  = vld;
    r.dat  = dat;
    r.due  = due;
    return r;
  endfunction

  task automatic popCheck(input int inst, input int port, input logic [3:0] vld, input logic [63:0] dat);
    ret_t e;
    if ((inst == 0 && expA.size() == 0) || (inst == 1 && expB.size() == 0)) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected return inst%0d port%0d: got valid %b, expected none", inst, port, vld);
    end else begin
      if (inst == 0) e = expA.pop_front();
      else           e = expB.pop_front();
      checkOutput("return port", 64'(port), 64'(e.port));
      checkOutput("return valid", 64'(vld), 64'(e.vld));
      checkOutput("return data", dat, e.dat);
      checkOutput("return cycle", 64'(cyc), 64'(e.due));
    end
  endtask

  // Read-return monitor, independent of the stimulus sequence.
  always @(negedge Clk) begin
    if (ifA.ChQValid0 != 4'b0) popCheck(0, 0, ifA.ChQValid0, ifA.ChQ0);
    if (ifA.ChQValid1 != 4'b0) popCheck(0, 1, ifA.ChQValid1, ifA.ChQ1);
    if (ifB.ChQValid0 != 4'b0) popCheck(1, 0, ifB.ChQValid0, ifB.ChQ0);
    if (ifB.ChQValid1 != 4'b0) popCheck(1, 1, ifB.ChQValid1, ifB.ChQ1);
  end

  task automatic applyStimulus();
    @(posedge Clk);
    #1;
    ifA.ChStart = '0; ifA.ChDone = '0; ifA.ChRd0 = '0; ifA.ChWr0 = '0; ifA.ChRd1 = '0; ifA.ChWr1 = '0;
    ifB.ChStart = '0; ifB.ChDone = '0; ifB.ChRd0 = '0; ifB.ChWr0 = '0; ifB.ChRd1 = '0; ifB.ChWr1 = '0;
    errClrA = 1'b0;
    errClrB = 1'b0;
  endtask

  initial begin
    resetA = 1'b0; resetB = 1'b0; errClrA = 1'b0; errClrB = 1'b0;
    ifA.ChStart = '0; ifA.ChDone = '0; ifA.ChMirror = '0;
    ifA.ChRd0 = '0; ifA.ChWr0 = '0; ifA.ChRd1 = '0; ifA.ChWr1 = '0;
    ifA.ChAddr0 = '0; ifA.ChAddr1 = '0; ifA.ChDat0 = '0; ifA.ChDat1 = '0;
    ifA.ChBase0 = '0; ifA.ChBase1 = '0;
    ifA.ChBase0[1*9 +: 9] = 9'h100;
    ifA.ChBase0[3*9 +: 9] = 9'h1F0;
    ifA.RamQ0 = Q0A; ifA.RamQ1 = Q1A;
    ifB.ChStart = '0; ifB.ChDone = '0; ifB.ChMirror = '0;
    ifB.ChRd0 = '0; ifB.ChWr0 = '0; ifB.ChRd1 = '0; ifB.ChWr1 = '0;
    ifB.ChAddr0 = '0; ifB.ChAddr1 = '0; ifB.ChDat0 = '0; ifB.ChDat1 = '0;
    ifB.ChBase0 = '0; ifB.ChBase1 = '0;
    ifB.RamQ0 = Q0B; ifB.RamQ1 = Q1B;

    applyStimulus();
    applyStimulus();
    checkOutput("reset grant", 64'(grantA), 64'h0);
    checkOutput("reset busy", 64'(busyA), 64'h0);
    checkOutput("reset err", 64'(errA), 64'h0);
    checkOutput("reset ram strobes", 64'({ifA.RamRd0, ifA.RamWr0, ifA.RamRd1, ifA.RamWr1}), 64'h0);
    checkOutput("reset ramaddr0", 64'(ifA.RamAddr0), 64'h0);
    checkOutput("reset qvalid", 64'({ifA.ChQValid0, ifA.ChQValid1}), 64'h0);
    resetA = 1'b1;
    resetB = 1'b1;

    // Instance A: first grant, relocated read, queued starts, round-robin handover.
    applyStimulus();
    ifA.ChStart[1] = 1'b1;
    #1 checkOutput("grant before edge", 64'(grantA), 64'h0);
    applyStimulus();
    checkOutput("grant ch1", 64'(grantA), 64'h2);
    checkOutput("busy ch1", 64'(busyA), 64'h1);
    ifA.ChRd0[1] = 1'b1;
    ifA.ChAddr0[1*9 +: 9] = 9'h005;
    ifA.ChStart[0] = 1'b1;
    ifA.ChStart[3] = 1'b1;
    expA.push_back(mkRet(0, 4'b0010, Q0A, cyc + 1));
    #1 checkOutput("ramrd0 ch1", 64'(ifA.RamRd0), 64'h1);
    checkOutput("ramaddr0 relocated", 64'(ifA.RamAddr0), 64'h105);
    applyStimulus();
    ifA.ChDone[1] = 1'b1;
    applyStimulus();
    checkOutput("drain keeps grant", 64'(grantA), 64'h2);
    applyStimulus();
    checkOutput("rr picks ch3", 64'(grantA), 64'h8);
    ifA.ChWr0[3] = 1'b1;
    ifA.ChAddr0[3*9 +: 9] = 9'h020;
    ifA.ChDat0[3*64 +: 64] = 64'h5555_AAAA_0000_FFFF;
    #1 checkOutput("ramwr0 ch3", 64'(ifA.RamWr0), 64'h1);
    checkOutput("ramaddr0 wrap", 64'(ifA.RamAddr0), 64'h010);
    checkOutput("ramdat0 ch3", ifA.RamDat0, 64'h5555_AAAA_0000_FFFF);
    applyStimulus();
    checkOutput("wrap no err", 64'(errA), 64'h0);
    ifA.ChDone[3] = 1'b1;
    applyStimulus();
    checkOutput("drain ch3", 64'(grantA), 64'h8);
    applyStimulus();
    checkOutput("rr wraps to ch0", 64'(grantA), 64'h1);
    ifA.ChDone[0] = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("idle grant", 64'(grantA), 64'h0);
    checkOutput("idle busy", 64'(busyA), 64'h0);

    // Instance A: mirroring, collision, errors and clear priority with ch2 owning.
    ifA.ChStart[2] = 1'b1;
    applyStimulus();
    checkOutput("grant ch2", 64'(grantA), 64'h4);
    ifA.ChMirror[2] = 1'b1;
    ifA.ChWr0[2] = 1'b1;
    ifA.ChAddr0[2*9 +: 9] = 9'h02D;
    ifA.ChDat0[2*64 +: 64] = 64'hDEAD_BEEF;
    #1 checkOutput("mirror ramwr1", 64'(ifA.RamWr1), 64'h1);
    checkOutput("mirror ramaddr1", 64'(ifA.RamAddr1), 64'h02D);
    checkOutput("mirror ramdat1", ifA.RamDat1, 64'hDEAD_BEEF);
    applyStimulus();
    checkOutput("mirror no err", 64'(errA), 64'h0);
    ifA.ChWr0[2] = 1'b1;
    ifA.ChWr1[2] = 1'b1;
    ifA.ChAddr1[2*9 +: 9] = 9'h077;
    ifA.ChDat1[2*64 +: 64] = 64'h1111;
    #1 checkOutput("collision ramaddr1", 64'(ifA.RamAddr1), 64'h02D);
    checkOutput("collision ramdat1", ifA.RamDat1, 64'hDEAD_BEEF);
    applyStimulus();
    checkOutput("collision err", 64'(errA), 64'h4);
    ifA.ChMirror[2] = 1'b0;
    errClrA = 1'b1;
    applyStimulus();
    checkOutput("errclr", 64'(errA), 64'h0);
    ifA.ChWr0[0] = 1'b1;
    #1 checkOutput("nonowner dropped", 64'(ifA.RamWr0), 64'h0);
    applyStimulus();
    checkOutput("nonowner err", 64'(errA), 64'h1);
    checkOutput("nonowner no steal", 64'(grantA), 64'h4);
    errClrA = 1'b1;
    applyStimulus();
    ifA.ChStart[2] = 1'b1;
    applyStimulus();
    checkOutput("restart err", 64'(errA), 64'h2);
    errClrA = 1'b1;
    ifA.ChStart[2] = 1'b1;
    applyStimulus();
    checkOutput("clear beats set", 64'(errA), 64'h0);
    ifA.ChRd1[2] = 1'b1;
    ifA.ChAddr1[2*9 +: 9] = 9'h033;
    expA.push_back(mkRet(1, 4'b0100, Q1A, cyc + 1));
    #1 checkOutput("ramrd1 ch2", 64'(ifA.RamRd1), 64'h1);
    checkOutput("ramaddr1 ch2", 64'(ifA.RamAddr1), 64'h033);
    applyStimulus();
    ifA.ChDone[2] = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("restart not queued", 64'(grantA), 64'h0);

    // Instance B: RD_LAT=3 drain delivers to old owner, then reset mid-DRAIN.
    ifB.ChStart[0] = 1'b1;
    applyStimulus();
    checkOutput("B grant ch0", 64'(grantB), 64'h1);
    ifB.ChRd0[0] = 1'b1;
    ifB.ChAddr0[0*9 +: 9] = 9'h010;
    k = cyc;
    expB.push_back(mkRet(0, 4'b0001, Q0B, k + 3));
    #1 checkOutput("B ramaddr0", 64'(ifB.RamAddr0), 64'h010);
    applyStimulus();
    ifB.ChDone[0] = 1'b1;
    ifB.ChStart[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("B drain holds grant", 64'(grantB), 64'h1);
    end
    applyStimulus();
    checkOutput("B grant ch1 after drain", 64'(grantB), 64'h2);
    ifB.ChRd0[1] = 1'b1;
    applyStimulus();
    ifB.ChDone[1] = 1'b1;
    applyStimulus();
    ifB.ChStart[3] = 1'b1;
    #2 resetB = 1'b0;
    #1 checkOutput("B reset grant", 64'(grantB), 64'h0);
    checkOutput("B reset busy", 64'(busyB), 64'h0);
    checkOutput("B reset ramaddr0", 64'(ifB.RamAddr0), 64'h0);
    checkOutput("B reset qvalid", 64'(ifB.ChQValid0), 64'h0);
    applyStimulus();
    resetB = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("B pending cleared", 64'(grantB), 64'h0);
    applyStimulus();

    checkOutput("A returns outstanding", 64'(expA.size()), 64'h0);
    checkOutput("B returns outstanding", 64'(expB.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pke_ram_arbiter.md
Name: pke_ram_arbiter

Overview:
- Parametrised successor to the PKE RAM port mux. Arbitrates NUM_CH PKE sub-engines onto the dual-port 64-bit PKE RAM (port 0 and port 1). Example sub-engines: basic long-arith, ModMul, ModInv, point engine.
- Replaces the fixed per-mode address offsets with per-channel base registers.
- Adds start/done ownership arbitration with a request queue, read-return routing, write mirroring, and error reporting.

Parameters:
- NUM_CH, 4: number of requesting engines.
- DW, 64: RAM data width.
- AW, 9: RAM word-address width.
- RD_LAT, 1: RAM read latency in cycles, from Rd strobe to Q valid; legal range 1..3.

Ports:
- Clk  in  1  clock
- Resetn  in  1  reset, asynchronous, active-low
- ChStart  in  NUM_CH  per-channel start pulse; requests RAM ownership
- ChDone  in  NUM_CH  per-channel done pulse; releases ownership
- ChMirror  in  NUM_CH  level; owner's port-0 writes are duplicated onto port 1
- ChRd0, ChWr0, ChRd1, ChWr1  in  NUM_CH each  per-channel port strobes
- ChAddr0, ChAddr1  in  NUM_CH*AW  per-channel offset addresses, channel c at bits [c*AW +: AW]
- ChDat0, ChDat1  in  NUM_CH*DW  per-channel write data
- ChBase0, ChBase1  in  NUM_CH*AW  per-channel base addresses, quasi-static
- RamRd0, RamWr0, RamRd1, RamWr1  out  1  RAM strobes
- RamAddr0, RamAddr1  out  AW  RAM addresses
- RamDat0, RamDat1  out  DW  RAM write data
- RamQ0, RamQ1  in  DW  RAM read data
- ChQ0, ChQ1  out  DW  read data broadcast to all channels
- ChQValid0, ChQValid1  out  NUM_CH  one-hot read-return valid per port
- Grant  out  NUM_CH  one-hot current owner; all zero when none
- Busy  out  1  owner present or drain in progress
- ErrClr  in  1  clears Err
- Err  out  3  sticky: [0] non-owner access, [1] start from the current owner, [2] mirror collision

Behaviour:
- Reset values:
  - Grant=0, Busy=0, Err=0, pending=0, last-owner pointer = NUM_CH-1.
  - Valid pipeline cleared; all Ram*/ChQValid outputs 0.
  - RamAddr/RamDat driven 0 when no owner.
- State machine IDLE / OWN / DRAIN:
  - IDLE: the pending vector is OR'd with ChStart. If nonzero, the next cycle grants the round-robin winner (first set bit after the last-owner pointer, wrapping) and goes to OWN. Grant-to-access latency is 1 cycle after Start.
  - OWN: accepts the owner's strobes. ChStart from other channels sets their pending bits. ChStart from the owner sets Err[1] and is otherwise ignored.
  - OWN exit: ChDone from the owner → DRAIN. Done from a non-owner is ignored.
  - DRAIN: lasts RD_LAT cycles. No new accesses; in-flight reads return to the old owner. Grant stays asserted but strobes are gated. Then → OWN with the next winner if pending is nonzero, else → IDLE.
  - Start and Done for the same channel in the same cycle while it owns: Done wins, Start is flagged Err[1].
- Datapath (combinational from the owner, no added latency):
  - RamAddrN = (ChBaseN[o] + ChAddrN[o]) mod 2^AW; wraps silently.
  - Strobes and data are passed through from the owner.
  - Non-owner strobes are dropped and set Err[0] (for a cycle-held strobe, set once).
- Mirror:
  - When ChMirror[o] & ChWr0[o]: RamWr1=1, RamAddr1=RamAddr0, RamDat1=RamDat0.
  - If the owner also drives Wr1 or Rd1 in that cycle, the mirror wins, the port-1 request is dropped, and Err[2] is set.
- Read return:
  - A shift register of depth RD_LAT per port carries {valid, owner index}.
  - ChQValidN[idx] asserts exactly RD_LAT cycles after the RamRdN strobe; ChQN = RamQN passed through.
- Err: bits OR-accumulate. ErrClr clears them, with priority over a same-cycle set.
- Asynchronous reset mid-operation aborts immediately: in-flight valids are lost and pending is cleared.

Decomposition:
- Shared package pke_pkg holds:
  - PKE_DW=64, PKE_AW=9.
  - Error bit indices ERR_NONOWN=0, ERR_RESTART=1, ERR_MIRROR=2.
  - Legacy base constants N_BASE_ECC=9'h024, M_BASE_ECC=9'h02D, N_BASE_RSA=9'h100, M_BASE_RSA=9'h180.
  - State encoding typedef.
- Sub-module pke_rr_pick: NUM_CH round-robin one-hot picker (request vector + last pointer → grant), reused by other PKE arbiters.

Test Plan:
- ChStart[1] pulse at cycle 0 → Grant=4'b0010 at cycle 1. ChRd0[1] with ChBase0[1]=9'h100, ChAddr0[1]=9'h005 → RamAddr0=9'h105, ChQValid0=4'b0010 one cycle later (RD_LAT=1).
- Ch1 owns and ChStart[0] and ChStart[3] pulse; ChDone[1] → 1 DRAIN cycle, then Grant=4'b1000 (round-robin after ch1 picks 3 before 0), then 4'b0001 after ch3 Done.
- Wrap: base 9'h1F0 + offset 9'h020 → RamAddr 9'h010, no error.
- Mirror: ChMirror[2]=1, ChWr0[2] addr 9'h02D, data 64'hDEAD_BEEF → RamWr1=1, RamAddr1=9'h02D, RamDat1 equal; adding ChWr1[2] the same cycle → Err=3'b100, port-1 request dropped.
- Non-owner ChWr0[0] while ch2 owns → RamWr0=0, Err[0]=1. ErrClr → Err=0. ChStart[2] while owning → Err[1]=1.
- RD_LAT=3: the owner reads, then Done the next cycle → ChQValid0 goes to the old owner at +3, and no new Grant before DRAIN completes. Reset asserted mid-DRAIN → all outputs 0 immediately.
